// File: rtl/axis_complex_frame_reader_pkg.sv
// Shared types, default widths and the shift-and-saturate arithmetic
// used by the complex frame reader.
package axis_complex_frame_reader_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_DRAIN = 2'd2
  } rd_state_e;

  localparam int DEF_AXIS_TDATA_WIDTH = 32;
  localparam int DEF_BRAM_DATA_WIDTH  = 64;
  localparam int DEF_BRAM_ADDR_WIDTH  = 32;
  localparam int DEF_FRAME_ADDR_WIDTH = 10;

  // Wide enough for any accumulator half up to 64 bits.
  localparam int SAT_CALC_WIDTH = 64;
  typedef logic signed [SAT_CALC_WIDTH-1:0] sat_calc_t;

  // Arithmetic right shift, then clamp into the signed range of out_width bits.
  function automatic sat_calc_t shift_saturate(input sat_calc_t  acc,
                                               input logic [4:0] shift,
                                               input int         out_width);
    sat_calc_t shifted;
    sat_calc_t max_val;
    sat_calc_t min_val;
    sat_calc_t result;
    shifted = acc >>> shift;
    max_val = (sat_calc_t'(1) <<< (out_width - 1)) - sat_calc_t'(1);
    min_val = -(sat_calc_t'(1) <<< (out_width - 1));
    if (shifted > max_val) begin
      result = max_val;
    end else if (shifted < min_val) begin
      result = min_val;
    end else begin
      result = shifted;
    end
    return result;
  endfunction

endpackage

// File: rtl/axis_complex_frame_reader_if.sv
// AXI4-Stream beat channel (data, valid, last, ready) carried by the frame
// reader's master port.
interface axis_complex_frame_reader_if #(
  parameter int TDATA_WIDTH = 32
) ();

  logic [TDATA_WIDTH-1:0] tdata;
  logic                   tvalid;
  logic                   tlast;
  logic                   tready;

  modport master (
    output tdata,
    output tvalid,
    output tlast,
    input  tready
  );

  modport slave (
    input  tdata,
    input  tvalid,
    input  tlast,
    output tready
  );

endinterface

// File: rtl/axis_complex_frame_reader_skid_fifo2.sv
// Two-entry output buffer; the head entry drives the stream directly so it
// stays stable while the consumer stalls.
module axis_skid_fifo2 #(
  parameter int WIDTH = 33
) (
  input  logic             aclk,
  input  logic             aresetn,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             valid,
  output logic [1:0]       count
);

  logic [WIDTH-1:0] mem_q [2];
  logic             wr_ptr_q;
  logic             rd_ptr_q;
  logic [1:0]       count_q;
  logic             push;
  logic             pop;

  assign pop  = rd_en && (count_q != 2'd0);
  assign push = wr_en && ((count_q != 2'd2) || pop);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      // NOTE: the storage is reset because the head entry is the visible
      // tdata/tlast, which must read zero out of reset.
      for (int i = 0; i < 2; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      if (push) begin
        mem_q[wr_ptr_q] <= wr_data;
        wr_ptr_q        <= ~wr_ptr_q;
      end
      if (pop) begin
        rd_ptr_q <= ~rd_ptr_q;
      end
      case ({push, pop})
        2'b10:   count_q <= count_q + 2'd1;
        2'b01:   count_q <= count_q - 2'd1;
        default: count_q <= count_q;
      endcase
    end
  end

  assign rd_data = mem_q[rd_ptr_q];
  assign valid   = (count_q != 2'd0);
  assign count   = count_q;

endmodule

// File: rtl/axis_complex_frame_reader.sv
// Streams one frame of complex accumulator words out of BRAM port B, scaling
// each {imag, real} half by 2^-n with saturation, as an AXI4-Stream frame.
module axis_complex_frame_reader
  import axis_complex_frame_reader_pkg::*;
#(
  parameter int AXIS_TDATA_WIDTH = DEF_AXIS_TDATA_WIDTH,
  parameter int BRAM_DATA_WIDTH  = DEF_BRAM_DATA_WIDTH,
  parameter int BRAM_ADDR_WIDTH  = DEF_BRAM_ADDR_WIDTH,
  parameter int FRAME_ADDR_WIDTH = DEF_FRAME_ADDR_WIDTH
) (
  input  logic                       aclk,
  input  logic                       aresetn,
  input  logic                       RD_start,
  input  logic [4:0]                 RD_log_count,
  output logic                       RD_busy,
  output logic [15:0]                RD_frame_count,
  axis_complex_frame_reader_if.master M_AXIS,
  output logic [BRAM_ADDR_WIDTH-1:0] bram_portb_addr,
  output logic                       bram_portb_clk,
  output logic                       bram_portb_en,
  input  logic [BRAM_DATA_WIDTH-1:0] bram_portb_rddata
);

  localparam int OUT_HALF_W = AXIS_TDATA_WIDTH / 2;
  localparam int ACC_HALF_W = BRAM_DATA_WIDTH / 2;
  localparam int ENTRY_W    = AXIS_TDATA_WIDTH + 1;
  localparam logic [FRAME_ADDR_WIDTH-1:0] LAST_ADDR = '1;

  rd_state_e                   state_q;
  rd_state_e                   state_d;
  logic [FRAME_ADDR_WIDTH-1:0] rd_addr_q;
  logic [4:0]                  log_count_q;
  logic                        rd_pending_q;
  logic                        rd_pending_last_q;
  logic [15:0]                 frame_count_q;

  logic                        start_accept;
  logic                        rd_issue;
  logic                        rd_issue_last;
  logic [2:0]                  in_use;

  logic [ENTRY_W-1:0]          fifo_wr_data;
  logic [ENTRY_W-1:0]          fifo_rd_data;
  logic                        fifo_valid;
  logic                        fifo_pop;
  logic [1:0]                  fifo_count;

  logic signed [ACC_HALF_W-1:0] acc_re;
  logic signed [ACC_HALF_W-1:0] acc_im;
  logic [OUT_HALF_W-1:0]        beat_re;
  logic [OUT_HALF_W-1:0]        beat_im;

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // NOTE: every combinational output gets a default first so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (RD_start)                  state_d = ST_READ;
      ST_READ:  if (rd_issue_last)             state_d = ST_DRAIN;
      ST_DRAIN: if (fifo_pop && M_AXIS.tlast)  state_d = ST_IDLE;
      default:                                 state_d = ST_IDLE;
    endcase
  end

  // A read may only go out if the buffer will still have room for it once
  // the beat leaving this cycle and the read already in the BRAM are counted.
  assign in_use = 3'(fifo_count) + 3'(rd_pending_q) - 3'(fifo_pop);

  always_comb begin
    RD_busy       = (state_q != ST_IDLE);
    start_accept  = (state_q == ST_IDLE) && RD_start;
    rd_issue      = (state_q == ST_READ) && (fifo_count != 2'd2) && (in_use < 3'd2);
    rd_issue_last = rd_issue && (rd_addr_q == LAST_ADDR);
  end

  // ------------------------------------------------------ read sequencing
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      rd_addr_q         <= '0;
      log_count_q       <= 5'd0;
      rd_pending_q      <= 1'b0;
      rd_pending_last_q <= 1'b0;
      frame_count_q     <= 16'd0;
    end else begin
      if (start_accept) begin
        rd_addr_q   <= '0;
        log_count_q <= RD_log_count;
      end else if (rd_issue && !rd_issue_last) begin
        rd_addr_q <= rd_addr_q + FRAME_ADDR_WIDTH'(1);
      end
      rd_pending_q      <= rd_issue;
      rd_pending_last_q <= rd_issue_last;
      if (fifo_pop && M_AXIS.tlast) begin
        frame_count_q <= frame_count_q + 16'd1;
      end
    end
  end

  assign bram_portb_clk  = aclk;
  assign bram_portb_en   = rd_issue;
  assign bram_portb_addr = BRAM_ADDR_WIDTH'(rd_addr_q);
  assign RD_frame_count  = frame_count_q;

  // ------------------------------------------------------------ datapath
  assign acc_re = bram_portb_rddata[ACC_HALF_W-1:0];
  assign acc_im = bram_portb_rddata[BRAM_DATA_WIDTH-1:ACC_HALF_W];

  assign beat_re = OUT_HALF_W'(shift_saturate(sat_calc_t'(acc_re), log_count_q, OUT_HALF_W));
  assign beat_im = OUT_HALF_W'(shift_saturate(sat_calc_t'(acc_im), log_count_q, OUT_HALF_W));

  assign fifo_wr_data = {rd_pending_last_q, beat_im, beat_re};

  axis_skid_fifo2 #(
    .WIDTH (ENTRY_W)
  ) u_out_buf (
    .aclk    (aclk),
    .aresetn (aresetn),
    .wr_en   (rd_pending_q),
    .wr_data (fifo_wr_data),
    .rd_en   (M_AXIS.tready),
    .rd_data (fifo_rd_data),
    .valid   (fifo_valid),
    .count   (fifo_count)
  );

  assign fifo_pop      = fifo_valid && M_AXIS.tready;
  assign M_AXIS.tvalid = fifo_valid;
  assign M_AXIS.tdata  = fifo_rd_data[AXIS_TDATA_WIDTH-1:0];
  assign M_AXIS.tlast  = fifo_rd_data[AXIS_TDATA_WIDTH];

endmodule

// File: tb/tb_axis_complex_frame_reader.sv
// Scoreboard bench for axis_complex_frame_reader with a 16-word frame and a
// 1-cycle-latency BRAM model.
module tb_axis_complex_frame_reader;

  localparam int FAW   = 4;
  localparam int DEPTH = 1 << FAW;
  localparam int TW    = 32;
  localparam int BW    = 64;
  localparam int AW    = 32;

  logic          aclk = 1'b0;
  logic          aresetn = 1'b0;
  logic          RD_start = 1'b0;
  logic [4:0]    RD_log_count = 5'd0;
  logic          RD_busy;
  logic [15:0]   RD_frame_count;
  logic [AW-1:0] bram_portb_addr;
  logic          bram_portb_clk;
  logic          bram_portb_en;
  logic [BW-1:0] bram_portb_rddata;

  axis_complex_frame_reader_if #(.TDATA_WIDTH(TW)) m_axis ();

  axis_complex_frame_reader #(
    .AXIS_TDATA_WIDTH (TW),
    .BRAM_DATA_WIDTH  (BW),
    .BRAM_ADDR_WIDTH  (AW),
    .FRAME_ADDR_WIDTH (FAW)
  ) dut (
    .aclk              (aclk),
    .aresetn           (aresetn),
    .RD_start          (RD_start),
    .RD_log_count      (RD_log_count),
    .RD_busy           (RD_busy),
    .RD_frame_count    (RD_frame_count),
    .M_AXIS            (m_axis),
    .bram_portb_addr   (bram_portb_addr),
    .bram_portb_clk    (bram_portb_clk),
    .bram_portb_en     (bram_portb_en),
    .bram_portb_rddata (bram_portb_rddata)
  );

  always #5 aclk = ~aclk;

  // BRAM model with one cycle of read latency.
  logic [BW-1:0] bram_mem [DEPTH];
  always @(posedge bram_portb_clk) begin
    if (bram_portb_en) bram_portb_rddata <= bram_mem[bram_portb_addr[FAW-1:0]];
  end

  int checks = 0;
  int errors = 0;
  int exp_frames = 0;

  task automatic check(input string name, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, actual, expected, $time);
    end
  endtask

  // ------------------------------------------------------------ scoreboard
  logic [TW:0] exp_q [$];
  logic [TW:0] exp_word;
  logic [TW:0] stall_word;
  bit          stall_valid = 1'b0;
  bit          pend_prev = 1'b0;
  int          exp_addr = 0;
  int          outstanding = 0;
  int          beats_seen = 0;

  always @(negedge aclk) begin
    if (aresetn) begin
      if (stall_valid) begin
        check("stall_tvalid", 64'(m_axis.tvalid), 64'd1);
        check("stall_beat", 64'({m_axis.tlast, m_axis.tdata}), 64'(stall_word));
      end
      if (m_axis.tvalid && m_axis.tready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL extra_beat: got %h with no beat expected (t=%0t)",
                   {m_axis.tlast, m_axis.tdata}, $time);
        end else begin
          exp_word = exp_q.pop_front();
          check("beat", 64'({m_axis.tlast, m_axis.tdata}), 64'(exp_word));
          beats_seen++;
        end
      end
      stall_valid = m_axis.tvalid && !m_axis.tready;
      stall_word  = {m_axis.tlast, m_axis.tdata};
      if (bram_portb_en) begin
        check("rd_addr", 64'(bram_portb_addr), 64'(exp_addr));
        check("rd_room", 64'((outstanding - 32'(m_axis.tvalid && m_axis.tready) < 2) &&
                             (outstanding - 32'(pend_prev) < 2)), 64'd1);
        exp_addr++;
      end
      outstanding = outstanding + 32'(bram_portb_en) - 32'(m_axis.tvalid && m_axis.tready);
      pend_prev   = bram_portb_en;
    end
    if (!aresetn || !RD_busy) begin
      exp_addr    = 0;
      outstanding = 0;
      pend_prev   = 1'b0;
      stall_valid = 1'b0;
      beats_seen  = 0;
    end
  end

  // -------------------------------------------------------------- stimulus
  task automatic fill_ramp();
    for (int k = 0; k < DEPTH; k++) bram_mem[k] = {32'(4 * k), 32'(-4 * k)};
  endtask

  // Expected beat for the ramp word {4k, -4k} with shift sh (sh <= 2).
  task automatic push_ramp(input int sh);
    for (int k = 0; k < DEPTH; k++) begin
      exp_q.push_back({(k == DEPTH - 1), 16'((4 * k) >> sh), 16'(-((4 * k) >> sh))});
    end
  endtask

  task automatic start_frame(input logic [4:0] n);
    @(posedge aclk); #1;
    RD_start     = 1'b1;
    RD_log_count = n;
    @(posedge aclk); #1;
    RD_start = 1'b0;
  endtask

  logic [11:0] bp_pattern = 12'b1001_1010_0011;

  task automatic run_frame(input bit backpressure, input bit mid_start, input bit check_latency);
    int cyc = 0;
    if (check_latency) begin
      @(negedge aclk);
      check("lat_en", 64'(bram_portb_en), 64'd1);
      check("lat_addr", 64'(bram_portb_addr), 64'd0);
      check("lat_busy", 64'(RD_busy), 64'd1);
      @(negedge aclk);
      check("lat_tvalid_e1", 64'(m_axis.tvalid), 64'd0);
      @(negedge aclk);
      check("lat_tvalid_e2", 64'(m_axis.tvalid), 64'd1);
    end
    while (RD_busy && cyc < 400) begin
      @(posedge aclk); #1;
      m_axis.tready = backpressure ? bp_pattern[cyc % 12] : 1'b1;
      if (mid_start && cyc == 4) begin
        RD_start     = 1'b1;
        RD_log_count = 5'd0;
      end else begin
        RD_start = 1'b0;
      end
      cyc++;
    end
    RD_start = 1'b0;
    m_axis.tready = 1'b1;
    exp_frames++;
    check("frame_done_busy", 64'(RD_busy), 64'd0);
    check("frame_count", 64'(RD_frame_count), 64'(exp_frames));
    check("beats_left", 64'(exp_q.size()), 64'd0);
  endtask

  logic [63:0] sat_words [4];
  logic [31:0] sat_exp   [4];

  initial begin
    int cyc;
    m_axis.tready = 1'b1;
    sat_words = '{64'h0010_0000_FFF0_0000, 64'h0000_7FFF_FFFF_8000,
                  64'h0000_8000_FFFF_7FFF, 64'hFFFF_FFFF_0000_0005};
    sat_exp   = '{32'h7FFF_8000, 32'h7FFF_8000, 32'h7FFF_8000, 32'hFFFF_0005};

    // Reset state
    @(negedge aclk);
    check("rst_tvalid", 64'(m_axis.tvalid), 64'd0);
    check("rst_tlast", 64'(m_axis.tlast), 64'd0);
    check("rst_tdata", 64'(m_axis.tdata), 64'd0);
    check("rst_en", 64'(bram_portb_en), 64'd0);
    check("rst_busy", 64'(RD_busy), 64'd0);
    check("rst_frame_count", 64'(RD_frame_count), 64'd0);
    @(posedge aclk); #1;
    aresetn = 1'b1;

    // Ramp, shift 2, full throughput, latency
    fill_ramp();
    push_ramp(2);
    start_frame(5'd2);
    run_frame(1'b0, 1'b0, 1'b1);

    // Saturation boundaries, shift 0
    fill_ramp();
    for (int k = 0; k < 4; k++) bram_mem[k] = sat_words[k];
    for (int k = 0; k < DEPTH; k++) begin
      if (k < 4) exp_q.push_back({1'b0, sat_exp[k]});
      else       exp_q.push_back({(k == DEPTH - 1), 16'(4 * k), 16'(-4 * k)});
    end
    start_frame(5'd0);
    run_frame(1'b0, 1'b0, 1'b0);

    // Backpressure, shift 1
    fill_ramp();
    push_ramp(1);
    start_frame(5'd1);
    run_frame(1'b1, 1'b0, 1'b0);

    // Start and shift change while busy are ignored
    push_ramp(2);
    start_frame(5'd2);
    run_frame(1'b0, 1'b1, 1'b0);

    // Reset in the middle of a frame, then a clean frame
    push_ramp(2);
    start_frame(5'd2);
    cyc = 0;
    while (beats_seen < 7 && cyc < 200) begin
      @(posedge aclk); #1;
      cyc++;
    end
    check("beat7_reached", 64'(beats_seen), 64'd7);
    aresetn = 1'b0;
    exp_q.delete();
    exp_frames = 0;
    #1;
    check("midrst_tvalid", 64'(m_axis.tvalid), 64'd0);
    check("midrst_busy", 64'(RD_busy), 64'd0);
    check("midrst_en", 64'(bram_portb_en), 64'd0);
    check("midrst_frame_count", 64'(RD_frame_count), 64'd0);
    repeat (2) @(posedge aclk);
    #1;
    aresetn = 1'b1;
    @(negedge aclk);
    check("post_rst_tvalid", 64'(m_axis.tvalid), 64'd0);
    push_ramp(2);
    start_frame(5'd2);
    run_frame(1'b0, 1'b0, 1'b0);

    repeat (3) @(posedge aclk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog expired");
  end

endmodule
